// File: rtl/fifo_pkg.sv
// Shared constants and grant encoding for the FIFO control stage.
package fifo_pkg;

  localparam int DATA_WIDTH_D    = 4;
  localparam int ADDRESS_WIDTH_D = 4;
  localparam int DEPTH_D         = 11;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } gnt_e;

  // Occupancy must reach DEPTH, which can equal 2^ADDRESS_WIDTH.
  function automatic int cnt_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer; wraps by explicit compare so DEPTH need not be a power of two.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_D,
  parameter int AW    = ADDRESS_WIDTH_D
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] ptr_r;

  // Pointer register: clear on reset, advance (with wrap) on enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {AW{1'b0}};
    end else if (inc) begin
      if (ptr_r == LAST) begin
        ptr_r <= {AW{1'b0}};
      end else begin
        ptr_r <= ptr_r + AW'(1);
      end
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control stage: arbitrates push/pop onto a single-port-per-cycle RAM and
// tracks occupancy and sticky error flags.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_D,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_D,
  parameter int DEPTH         = DEPTH_D
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_req,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     wr_ack,
  input  logic                     rd_req,
  output logic                     rd_ack,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  input  logic [DATA_WIDTH-1:0]    ram_dout,
  output logic [DATA_WIDTH-1:0]    ram_din,
  output logic                     ram_cs,
  output logic                     ram_we,
  output logic                     ram_oe,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_wr,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_rd,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int CW = cnt_width(ADDRESS_WIDTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]            count_r;
  logic                     full_r;
  logic                     empty_r;
  logic                     overflow_r;
  logic                     underflow_r;
  logic                     rd_valid_r;
  logic                     prio_wr_r;
  logic [ADDRESS_WIDTH-1:0] rd_addr_hold_r;

  logic                     wr_ok_s;
  logic                     rd_ok_s;
  gnt_e                     gnt_s;
  logic [ADDRESS_WIDTH-1:0] wr_ptr_s;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_s;

  assign wr_ok_s = wr_req & ~full_r;
  assign rd_ok_s = rd_req & ~empty_r;

  // Round-robin grant; reset blocks every grant so no strobe escapes.
  always_comb begin
    gnt_s = GNT_NONE;
    if (rst) begin
      gnt_s = GNT_NONE;
    end else if (wr_ok_s && rd_ok_s) begin
      gnt_s = prio_wr_r ? GNT_WR : GNT_RD;
    end else if (wr_ok_s) begin
      gnt_s = GNT_WR;
    end else if (rd_ok_s) begin
      gnt_s = GNT_RD;
    end else begin
      gnt_s = GNT_NONE;
    end
  end

  // RAM strobes and acks follow the grant in the same cycle.
  always_comb begin
    wr_ack      = 1'b0;
    rd_ack      = 1'b0;
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_oe      = 1'b0;
    ram_addr_wr = wr_ptr_s;
    ram_addr_rd = rd_addr_hold_r;
    case (gnt_s)
      GNT_WR: begin
        wr_ack = 1'b1;
        ram_cs = 1'b1;
        ram_we = 1'b1;
      end
      GNT_RD: begin
        // The RAM indexes reads through its write-address port.
        rd_ack      = 1'b1;
        ram_cs      = 1'b1;
        ram_oe      = 1'b1;
        ram_addr_wr = rd_ptr_s;
        ram_addr_rd = rd_ptr_s;
      end
      default: begin
        wr_ack = 1'b0;
        rd_ack = 1'b0;
      end
    endcase
  end

  // Occupancy, flags, read-valid pipeline, priority and held read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r        <= {CW{1'b0}};
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
      rd_valid_r     <= 1'b0;
      prio_wr_r      <= 1'b1;
      rd_addr_hold_r <= {ADDRESS_WIDTH{1'b0}};
    end else begin
      rd_valid_r <= (gnt_s == GNT_RD);
      if (wr_req && full_r) begin
        overflow_r <= 1'b1;
      end
      if (rd_req && empty_r) begin
        underflow_r <= 1'b1;
      end
      if (wr_ok_s && rd_ok_s) begin
        prio_wr_r <= ~prio_wr_r;
      end
      case (gnt_s)
        GNT_WR: begin
          count_r <= count_r + CW'(1);
          full_r  <= ((count_r + CW'(1)) == DEPTH_C);
          empty_r <= 1'b0;
        end
        GNT_RD: begin
          count_r        <= count_r - CW'(1);
          full_r         <= 1'b0;
          empty_r        <= ((count_r - CW'(1)) == {CW{1'b0}});
          rd_addr_hold_r <= rd_ptr_s;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(ADDRESS_WIDTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (gnt_s == GNT_WR),
    .ptr (wr_ptr_s)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH), .AW(ADDRESS_WIDTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (gnt_s == GNT_RD),
    .ptr (rd_ptr_s)
  );

  // A read granted just before reset must not surface as valid data.
  assign rd_valid  = rd_valid_r & ~rst;
  assign rd_data   = ram_dout;
  assign ram_din   = wr_data;
  assign count     = count_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized self-checking bench for fifo_ctrl against a queue-based FIFO model.
module tb_fifo_ctrl;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DEPTH = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          rd_req;
  logic          rd_ack;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] ram_din;
  logic          ram_cs;
  logic          ram_we;
  logic          ram_oe;
  logic [AW-1:0] ram_addr_wr;
  logic [AW-1:0] ram_addr_rd;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  int            m_wptr;
  int            m_rptr;
  int            m_hold;
  bit            m_prio_wr;
  bit            m_ovf;
  bit            m_unf;
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            grants_w;
  int            grants_r;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  fifo_ctrl #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_dout(ram_dout), .ram_din(ram_din), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_oe(ram_oe), .ram_addr_wr(ram_addr_wr), .ram_addr_rd(ram_addr_rd),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Behavioural storage RAM: reads index through the write-address port.
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_addr_wr] <= ram_din;
    if (ram_cs && ram_oe) ram_dout <= mem[ram_addr_wr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_wptr = 0; m_rptr = 0; m_hold = 0;
    m_prio_wr = 1'b1; m_ovf = 1'b0; m_unf = 1'b0; m_valid = 1'b0;
  endtask

  // Hold rst for one edge with both requests high; nothing may be granted.
  task automatic do_reset();
    rst = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_data = 4'hF;
    #4;
    check("rst_wr_ack", 32'(wr_ack), 32'd0);
    check("rst_rd_ack", 32'(rd_ack), 32'd0);
    check("rst_ram_cs", 32'(ram_cs), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_ram_oe", 32'(ram_oe), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive, check against model at mid-cycle, advance model.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r);
    bit m_full, m_empty, wok, rok;
    int g; // 0 none, 1 write, 2 read
    wr_req = w; wr_data = d; rd_req = r;
    #4;
    m_full  = (q.size() == DEPTH);
    m_empty = (q.size() == 0);
    wok = w && !m_full;
    rok = r && !m_empty;
    if (wok && rok) g = m_prio_wr ? 1 : 2;
    else if (wok)   g = 1;
    else if (rok)   g = 2;
    else            g = 0;

    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(m_full));
    check("empty", 32'(empty), 32'(m_empty));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    if (m_valid) check("rd_data", 32'(rd_data), 32'(m_data));
    check("wr_ack", 32'(wr_ack), 32'(g == 1));
    check("rd_ack", 32'(rd_ack), 32'(g == 2));
    check("ram_cs", 32'(ram_cs), 32'(g != 0));
    check("ram_we", 32'(ram_we), 32'(g == 1));
    check("ram_oe", 32'(ram_oe), 32'(g == 2));
    check("we_oe_excl", 32'(ram_we & ram_oe), 32'd0);
    check("ram_addr_wr", 32'(ram_addr_wr), 32'((g == 2) ? m_rptr : m_wptr));
    check("ram_addr_rd", 32'(ram_addr_rd), 32'((g == 2) ? m_rptr : m_hold));
    if (g == 1) check("ram_din", 32'(ram_din), 32'(d));

    if (w && m_full)  m_ovf = 1'b1;
    if (r && m_empty) m_unf = 1'b1;
    if (wok && rok)   m_prio_wr = !m_prio_wr;
    m_valid = (g == 2);
    if (g == 1) begin
      q.push_back(d);
      m_wptr = (m_wptr + 1) % DEPTH;
      grants_w++;
    end
    if (g == 2) begin
      m_data = q.pop_front();
      m_hold = m_rptr;
      m_rptr = (m_rptr + 1) % DEPTH;
      grants_r++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_data = 4'h0;
    grants_w = 0; grants_r = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);

    // Fill to DEPTH, then one push into a full FIFO.
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 4'(i), 1'b0);
    cycle(1'b1, 4'hC, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);

    // Drain completely, then one pop from an empty FIFO.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);

    // Wrap-around: push 6 / pop 6 twice from a fresh reset.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 6 * k + 1), 1'b0);
      for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b1);
    end
    cycle(1'b0, 4'h0, 1'b0);

    // Contention at count 5 after reset: grants alternate starting with write.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 3), 1'b0);
    grants_w = 0; grants_r = 0;
    for (int i = 0; i < 10; i++) cycle(1'b1, 4'(i), 1'b1);
    check("alt_wr_grants", 32'(grants_w), 32'd5);
    check("alt_rd_grants", 32'(grants_r), 32'd5);

    // Read grant immediately followed by reset: its rd_valid is suppressed.
    cycle(1'b0, 4'h0, 1'b1);
    do_reset();
    cycle(1'b0, 4'h0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 4'($urandom), 1'($urandom_range(0, 99) < 50));
    end
    cycle(1'b0, 4'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Control stage directly upstream of the FIFO storage RAM.
- Turns producer push requests and consumer pop requests into the RAM's chip-select, write-enable, output-enable and address strobes.
- Tracks read/write pointers, occupancy, full/empty and sticky error flags.
- The RAM performs one operation per cycle, so simultaneous push and pop are arbitrated round-robin.

Parameters:
- DATA_WIDTH, 4, width of FIFO words.
- ADDRESS_WIDTH, 4, width of RAM address ports.
- DEPTH, 11, number of usable entries; must be ≤ 2^ADDRESS_WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- wr_req  in  1  producer push request (level)
- wr_data  in  DATA_WIDTH  push data
- wr_ack  out  1  push accepted this cycle
- rd_req  in  1  consumer pop request (level)
- rd_ack  out  1  pop accepted this cycle
- rd_valid  out  1  rd_data valid (one cycle after rd_ack)
- rd_data  out  DATA_WIDTH  pop data
- ram_dout  in  DATA_WIDTH  RAM read data
- ram_din  out  DATA_WIDTH  RAM write data
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable
- ram_addr_wr  out  ADDRESS_WIDTH  RAM write-address port
- ram_addr_rd  out  ADDRESS_WIDTH  RAM read-address port
- count  out  ADDRESS_WIDTH+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: wr_req seen while full
- underflow  out  1  sticky: rd_req seen while empty

Behaviour:
- Reset (rst high at a clk edge):
  - wr_ptr = 0, rd_ptr = 0, count = 0; empty = 1, full = 0.
  - overflow = 0, underflow = 0, rd_valid = 0.
  - Priority flag set to favour write; held read address = 0.
  - While rst is high, all acks and RAM strobes are forced to 0.
- Eligibility: wr_ok = wr_req & !full; rd_ok = rd_req & !empty.
- Grant (combinational, from req and registered state):
  - Only one of wr_ok/rd_ok true → grant it.
  - Both true → grant the side the priority flag favours; the flag then toggles to favour the other side.
  - A single grant leaves the flag unchanged.
  - The losing request stays pending; the requester holds req and data until its ack.
- Write grant, same cycle:
  - wr_ack = 1; ram_cs = 1, ram_we = 1, ram_oe = 0.
  - ram_addr_wr = wr_ptr; ram_din = wr_data.
- Read grant, same cycle:
  - rd_ack = 1; ram_cs = 1, ram_we = 0, ram_oe = 1.
  - ram_addr_wr = rd_ptr AND ram_addr_rd = rd_ptr. On reads the storage RAM indexes its array through the write-address port, so both ports carry the read pointer.
- No grant: ram_cs = ram_we = ram_oe = 0.
- ram_addr_rd holding:
  - Holds the last read address (registered) in every cycle that is not a read grant.
  - The RAM output stays valid until the next read.
- ram_addr_wr when no grant: equals wr_ptr.
- Read latency: rd_valid = 1 exactly one cycle after rd_ack; rd_data = ram_dout, passed through combinationally.
- Pointers:
  - Increment at the edge after their grant.
  - Wrap from DEPTH-1 to 0 by explicit compare (DEPTH need not be a power of 2).
- count: +1 on a write grant, −1 on a read grant. At most one grant per cycle, so count never changes by more than 1.
- full and empty: registered, updated with count.
- Boundaries:
  - wr_req while full → no ack; overflow set. rd_req while empty → no ack; underflow set. Both flags are sticky until rst.
  - Full with both requests → only rd eligible, read granted, flag unchanged. Empty with both → write granted.
- Reset mid-operation: a pending rd_valid from a read granted in the cycle before rst is suppressed; no RAM strobe is issued during rst.

Decomposition:
- Shared package (fifo_pkg):
  - Default DATA_WIDTH/ADDRESS_WIDTH/DEPTH constants.
  - Grant encoding constants: GNT_NONE, GNT_WR, GNT_RD.
  - Function for count width.
- One natural sub-module: fifo_wrap_ptr, a modulo-DEPTH pointer with increment enable and synchronous reset, instanced twice (write and read).
- Arbitration and flags stay in fifo_ctrl.

Test Plan:
- Reset, then idle → count = 0, empty = 1, full = 0, ram_cs = 0, rd_valid = 0, no acks.
- Push 0x1..0xB (11 words), then wr_req with 0xC:
  - 11 wr_acks; ram_addr_wr steps 0..10; full = 1; count = 11.
  - 12th push gets no ack; overflow = 1.
- From full, pop 11 times:
  - rd_data = 0x1..0xB, each one cycle after rd_ack; ram_addr_wr = ram_addr_rd = rd_ptr on each read.
  - empty = 1; a further pop sets underflow = 1.
- Wrap-around: push 6/pop 6 twice with DEPTH = 11 → write pointer goes 10→0 on the 11th write; data order preserved; count back to 0.
- wr_req and rd_req held high with count = 5:
  - Grants alternate W, R, W, R… starting with W after reset; count oscillates 5↔6.
  - ram_we and ram_oe are never high together.
- rst asserted in the cycle after a read grant → rd_valid stays 0; count = 0, overflow = 0, underflow = 0 on the next cycle.
